// File: rtl/mlp_pkg.sv
// mlp_pkg: shared FP32 type, ordering helpers and argmax FSM states
package mlp_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP32_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    function automatic logic isnan_f32(input fp32_t x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Maps a non-NaN FP32 value to an unsigned key with the same ordering; -0 folds onto +0
    function automatic logic [31:0] f32_order_key(input fp32_t x);
        fp32_t n;
        n = (x == 32'h8000_0000) ? FP32_ZERO : x;
        return n[31] ? ~n : n ^ 32'h8000_0000;
    endfunction

endpackage

// File: rtl/fp32_compare.sv
// fp32_compare: combinational a > b for FP32 where NaN ranks below every number and never wins
module fp32_compare
    import mlp_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output logic  a_gt_b
);

    assign a_gt_b = !isnan_f32(a) && (isnan_f32(b) || (f32_order_key(a) > f32_order_key(b)));

endmodule

// File: rtl/mlp_argmax.sv
// mlp_argmax: snapshots the final layer scores and scans them sequentially for the winning class
module mlp_argmax
    import mlp_pkg::*;
#(
    parameter int N_CLASSES = 10,
    parameter int IDX_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  fp32_t            scores [0:N_CLASSES-1],
    input  logic             layer_end,
    input  logic             result_ack,
    output logic [IDX_W-1:0] class_idx,
    output fp32_t            max_value,
    output logic             nan_seen,
    output logic             valid,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);

    state_t           state, state_d;
    fp32_t            snap [0:N_CLASSES-1];
    logic [IDX_W-1:0] ptr;
    logic             layer_end_q, pending, start, capture, step, cand_gt;
    fp32_t            cand;

    assign start = layer_end && !layer_end_q;
    assign cand  = snap[ptr];

    fp32_compare u_cmp (
        .a      (cand),
        .b      (max_value),
        .a_gt_b (cand_gt)
    );

    // Next state: capture from IDLE or on the ack edge when a start is waiting
    always_comb begin
        state_d = state;
        capture = 1'b0;
        step    = 1'b0;
        case (state)
            S_IDLE: capture = start || pending;
            S_SCAN: begin
                step = 1'b1;
                if (ptr == LAST) state_d = S_DONE;
            end
            S_DONE: if (result_ack) begin
                capture = start || pending;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (capture) state_d = (N_CLASSES == 1) ? S_DONE : S_SCAN;
    end

    // State register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_d;
    end

    // Snapshot isolates the scan from the producer; contents are don't-care until captured
    always_ff @(posedge CLK) begin
        if (capture) snap <= scores;
    end

    // Running best doubles as the registered result, frozen once DONE is reached
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            layer_end_q <= 1'b0;
            pending     <= 1'b0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            class_idx   <= '0;
            max_value   <= FP32_ZERO;
            nan_seen    <= 1'b0;
            ptr         <= '0;
        end else begin
            layer_end_q <= layer_end;
            pending     <= !capture && (pending || (start && state != S_IDLE));
            valid       <= state_d == S_DONE;
            busy        <= state_d == S_SCAN;
            if (capture) begin
                class_idx <= '0;
                max_value <= scores[0];
                nan_seen  <= isnan_f32(scores[0]);
                ptr       <= IDX_W'(1);
            end else if (step) begin
                if (cand_gt) begin
                    max_value <= cand;
                    class_idx <= ptr;
                end
                nan_seen <= nan_seen || isnan_f32(cand);
                ptr      <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: doc/mlp_argmax.md
# mlp_argmax

Sequential classifier stage that consumes the final dense layer's FP32 output vector and its `layer_end` completion flag. It snapshots the vector, scans it one element per cycle with an IEEE-754-aware comparator, and reports the winning class index and score through a valid/ack handshake. It sits between the last `layer` instance and the MLP top-level result port, and is the reader side of the layer's `outputs`/`layer_end` interface.

## Interface
- `N_CLASSES`, 10, number of FP32 scores (final layer `N_NEURONS`), ≥1
- `IDX_W`, `$clog2(N_CLASSES)` (min 1), width of class index
- `CLK` input 1, single clock, all state on rising edge
- `reset_n` input 1, reset is asynchronous and active-low
- `scores` input [31:0] x `[0:N_CLASSES-1]`, final layer outputs, IEEE-754 single
- `layer_end` input 1, level flag from producing layer, high = vector valid
- `result_ack` input 1, consumer accepts current result
- `class_idx` output `IDX_W`, index of maximum score
- `max_value` output 32, FP32 value at `class_idx`
- `nan_seen` output 1, at least one snapshot element was NaN
- `valid` output 1, result stable and held until acked
- `busy` output 1, snapshot taken, scan in progress

## Operation
- States: IDLE, SCAN, DONE.
- Start event: `layer_end`=1 and registered `layer_end_q`=0 (rising edge).
- IDLE + start: copy `scores` into internal snapshot; best←snap[0], idx←0, ptr←1, `nan_seen`←isnan(snap[0]); go SCAN (or DONE directly if `N_CLASSES`=1).
- SCAN: each cycle compare snap[ptr] against best; replace only on strictly greater; ptr++; after ptr = N_CLASSES-1 is processed, go DONE.
- DONE: `valid`=1, outputs frozen; on `result_ack`=1 go IDLE (or straight into a new capture if pending set).
- Start event during SCAN/DONE: set `pending`; serviced on the ack edge (capture uses `scores` at that edge). Multiple events collapse into one.
- Comparison: NaN (exp=FF, mant≠0) never wins and never replaced-by; -0 normalised to +0; otherwise key = sign ? ~bits : bits ^ 32'h8000_0000, unsigned compare. ±Inf ordered normally.
- Ties: lowest index wins.
- All-NaN vector: `class_idx`=0, `max_value`=snap[0] (NaN), `nan_seen`=1.
- Snapshot isolates scan from producer: `scores`/`layer_end` may change or reset mid-scan without effect.

## Timing
- Reset (async, any state): IDLE, `valid`=0, `busy`=0, `class_idx`=0, `max_value`=0, `nan_seen`=0, `pending`=0, `layer_end_q`=0. A `layer_end` held high across reset release starts a scan on the first edge.
- Capture edge E0; `busy`=1 from E0 to DONE entry.
- `valid` rises at edge E0+(N_CLASSES-1); N_CLASSES=10 → 9 edges after capture. N_CLASSES=1 → `valid` at E0.
- `valid` falls on the edge sampling `result_ack`=1 in DONE; `result_ack` ignored outside DONE.
- Ack with pending: `valid` falls, `busy` rises same edge, new result after N_CLASSES-1 further edges.
- Outputs are registered; no combinational path input→output.

## Structure
- `mlp_pkg`: `typedef logic [31:0] fp32_t`, `FP32_ZERO`, `isnan_f32` and `f32_order_key` functions, state enum.
- Sub-module `fp32_compare` (combinational `a_gt_b` with NaN/±0 rules), reusable by other MLP stages.

## Test plan
- Scores {1.0,3F800000; 2.0,40000000; rest BF800000}, raise `layer_end` → `valid` 9 edges later, `class_idx`=1, `max_value`=40000000, `nan_seen`=0.
- snap[3]=snap[7]=40400000 (3.0), others 0 → `class_idx`=3 (lowest index tie).
- snap[0]=80000000 (-0), snap[5]=00000000, others BF800000 → `class_idx`=0 (±0 equal).
- snap[2]=7FC00000 (NaN), snap[4]=3F800000, others 0 → `class_idx`=4, `nan_seen`=1; all-NaN → `class_idx`=0, `max_value`=7FC00000.
- Change `scores` and drop `layer_end` mid-scan → result from snapshot; retoggle `layer_end` in DONE → after ack, second scan starts same edge.
- Assert `reset_n`=0 mid-scan → all outputs zero immediately; release with `layer_end`=1 → new scan starts on first edge.
